// File: rtl/rgb_cap_pkg.sv
// rgb_cap_pkg: register offsets, ID constant and enums shared by rgb_capture and its channels
package rgb_cap_pkg;
   localparam logic [31:0] RGB_CAP_ID     = 32'd0;
   localparam logic [31:0] RGB_CAP_CTRL   = 32'd1;
   localparam logic [31:0] RGB_CAP_STATUS = 32'd2;
   localparam logic [31:0] RGB_CAP_CH_R   = 32'd3;
   localparam logic [31:0] RGB_CAP_CH_G   = 32'd4;
   localparam logic [31:0] RGB_CAP_CH_B   = 32'd5;
   localparam logic [15:0] RGB_CAP_ID_CONST = 16'h52C0;
   typedef enum logic [1:0] {IDLE, ARM, MEAS} chan_state_t;
   typedef enum logic [1:0] {CH_R = 2'd0, CH_G = 2'd1, CH_B = 2'd2} ch_idx_t;
endpackage

// File: rtl/intbus_interf.sv
// intbus_interf: internal word-addressed bus; clk, async active-low resetn, wr/rd strobes, registered rdata
interface intbus_interf;
   logic        clk;
   logic        resetn;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        wr;
   logic        rd;
   modport responder (input clk, resetn, addr, wdata, wr, rd, output rdata);
endinterface

// File: rtl/rgb_cap_channel.sv
// rgb_cap_channel: one PWM input -> sync, optional glitch filter (RGB_CAP_FILTER_EN), edge detect, IDLE/ARM/MEAS counters
// Ports: clk, resetn (async active-low), pin (async PWM), en, clr (strobe);
//        pub (measurement ready pulse), stuck (saturation pulse), period/high (held measurement).
module rgb_cap_channel
   import rgb_cap_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pin,
   input  logic             en,
   input  logic             clr,
   output logic             pub,
   output logic             stuck,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high
);
   localparam logic [CNT_W-1:0] MAX = '1;
   logic [1:0] s;
   logic lvl, prev, rise;
   chan_state_t st;
   logic [CNT_W-1:0] pcnt, hcnt;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         s <= '0;
         prev <= 1'b0;
      end else begin
         s <= {s[0], pin};
         prev <= lvl;
      end
`ifdef RGB_CAP_FILTER_EN
   // level only follows the synced sample after three equal samples in a row
   logic [1:0] h;
   logic flt;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         h <= '0;
         flt <= 1'b0;
      end else begin
         h <= {h[0], s[1]};
         flt <= lvl;
      end
   assign lvl = (&{h, s[1]}) ? 1'b1 : (~|{h, s[1]}) ? 1'b0 : flt;
`else
   assign lvl = s[1];
`endif
   assign rise = lvl & ~prev;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         st <= IDLE;
         pcnt <= '0;
         hcnt <= '0;
         pub <= 1'b0;
         stuck <= 1'b0;
         period <= '0;
         high <= '0;
      end else begin
         pub <= 1'b0;
         stuck <= 1'b0;
         if (!en) begin
            st <= IDLE;
            pcnt <= '0;
            hcnt <= '0;
         end else if (clr) begin
            st <= ARM;
            pcnt <= '0;
            hcnt <= '0;
         end else
            case (st)
               IDLE: st <= ARM;
               ARM:
                  if (rise) begin
                     st <= MEAS;
                     pcnt <= CNT_W'(1);
                     hcnt <= CNT_W'(1);
                  end
               MEAS:
                  if (rise) begin
                     pub <= 1'b1;
                     period <= pcnt;
                     high <= hcnt;
                     pcnt <= CNT_W'(1);
                     hcnt <= CNT_W'(1);
                  end else if (pcnt == MAX) begin
                     pub <= 1'b1;
                     stuck <= 1'b1;
                     period <= MAX;
                     high <= lvl ? MAX : '0;
                     st <= ARM;
                     pcnt <= '0;
                     hcnt <= '0;
                  end else begin
                     pcnt <= pcnt + CNT_W'(1);
                     hcnt <= hcnt + CNT_W'(lvl);
                  end
               default: st <= IDLE;
            endcase
      end
endmodule

// File: rtl/rgb_capture.sv
// rgb_capture: three-channel PWM period/high-time capture on intbus_interf (RGB_CAP_FILTER_EN adds glitch filter)
// Ports: bus (responder, words BASEADDR+0..5), R/G/B async PWM inputs.
// Map: 0 ID, 1 CTRL {CLR,EN}, 2 STATUS W1C {STUCK[6:4],VALID[2:0]}, 3..5 CH_R/G/B {period,high}.
module rgb_capture
   import rgb_cap_pkg::*;
#(
   parameter int BASEADDR = 0,
   parameter int CNT_W    = 16
) (
   intbus_interf.responder bus,
   input logic R,
   input logic G,
   input logic B
);
   logic en, clr, wsel_ctrl, wsel_stat;
   logic [2:0] pins, pub, stk_p, valid, stk, w1c_v, w1c_s;
   logic [CNT_W-1:0] per [3];
   logic [CNT_W-1:0] hi [3];
   logic [31:0] ch [3];
   logic [31:0] off, rmux;
   logic unused;
   assign pins = {B, G, R};
   assign unused = ^{bus.wdata[31:7], bus.wdata[3]};
   for (genvar i = 0; i < 3; i++) begin : g_ch
      rgb_cap_channel #(.CNT_W(CNT_W)) u_ch (
         .clk(bus.clk), .resetn(bus.resetn), .pin(pins[i]), .en(en), .clr(clr),
         .pub(pub[i]), .stuck(stk_p[i]), .period(per[i]), .high(hi[i])
      );
   end
   assign off = bus.addr - 32'(BASEADDR);
   assign wsel_ctrl = bus.wr && off == RGB_CAP_CTRL;
   assign wsel_stat = bus.wr && off == RGB_CAP_STATUS;
   assign clr = wsel_ctrl & bus.wdata[1];
   assign w1c_v = wsel_stat ? bus.wdata[2:0] : 3'b0;
   assign w1c_s = wsel_stat ? bus.wdata[6:4] : 3'b0;
   always_comb
      rmux = off == RGB_CAP_ID     ? {16'(CNT_W), RGB_CAP_ID_CONST} :
             off == RGB_CAP_CTRL   ? {31'd0, en} :
             off == RGB_CAP_STATUS ? {25'd0, stk, 1'b0, valid} :
             off == RGB_CAP_CH_R   ? ch[CH_R] :
             off == RGB_CAP_CH_G   ? ch[CH_G] :
             off == RGB_CAP_CH_B   ? ch[CH_B] : 32'd0;
   // sets are OR-ed after the W1C mask so a same-cycle set survives; CLR overrides everything
   always_ff @(posedge bus.clk or negedge bus.resetn)
      if (!bus.resetn) begin
         en <= 1'b0;
         valid <= '0;
         stk <= '0;
         for (int k = 0; k < 3; k++) ch[k] <= '0;
         bus.rdata <= '0;
      end else begin
         if (wsel_ctrl) en <= bus.wdata[0];
         if (clr) begin
            valid <= '0;
            stk <= '0;
            for (int k = 0; k < 3; k++) ch[k] <= '0;
         end else begin
            valid <= (valid & ~w1c_v) | pub;
            stk <= (stk & ~w1c_s) | stk_p;
            for (int k = 0; k < 3; k++) if (pub[k]) ch[k] <= {16'(per[k]), 16'(hi[k])};
         end
         bus.rdata <= bus.rd ? rmux : 32'd0;
      end
endmodule
